lsu_mem_ctrl: RTL and testbench
===============================

# lsu_mem_ctrl

CPU-side load/store unit that initiates data-memory transactions for the pipeline's memory stage. It accepts one load/store command at a time from the core over a valid/ready handshake and issues word-aligned requests with byte enables and lane-shifted write data. For loads it extracts the addressed byte or halfword from the returned word and sign- or zero-extends it per funct3. A small state machine sequences each access and, when enabled, splits word-crossing misaligned accesses into two beats.

## Interface
- ADDR_WIDTH, 32, byte-address width
- DATA_WIDTH, 32, data word width (fixed at 32, 4 byte lanes)

- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  core command valid
- req_ready  out  1  LSU can accept a command (high only in IDLE)
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3 (000 b, 001 h, 010 w, 100 bu, 101 hu)
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  DATA_WIDTH  store data, right-aligned
- rsp_valid  out  1  one-cycle pulse, command complete
- rsp_rdata  out  DATA_WIDTH  extended load result (0 for stores and errors)
- rsp_err  out  1  illegal funct3 or unsupported misalignment, valid with rsp_valid
- mem_req  out  1  memory request
- mem_we  out  1  memory write
- mem_addr  out  ADDR_WIDTH  word-aligned address (bits [1:0] = 0)
- mem_be  out  4  byte enables
- mem_wdata  out  DATA_WIDTH  lane-shifted write data
- mem_ack  in  1  memory accepted/completed current beat
- mem_rdata  in  DATA_WIDTH  read word, valid in the mem_ack cycle

## Operation
- States: IDLE, ACC0, ACC1, RESP.
- IDLE: req_ready=1. On req_valid&req_ready latch we, funct3, addr, wdata.
  - Legal: loads 000/001/010/100/101; stores 000/001/010. Illegal -> RESP with err=1, no memory access.
  - Otherwise -> ACC0.
- off = addr[1:0]; size mask m = 0001 (b), 0011 (h), 1111 (w). 8-bit enable E = m << off; 64-bit data W = {32'b0, wdata} << (8*off).
- ACC0: mem_req=1, mem_addr = {addr[31:2],00}, mem_be = E[3:0], mem_wdata = W[31:0]. On mem_ack: capture mem_rdata into low buffer; go ACC1 if E[7:4]!=0, else RESP.
- ACC1: mem_addr = previous word + 4 (wraps modulo 2^ADDR_WIDTH), mem_be = E[7:4], mem_wdata = W[63:32]. On mem_ack: capture into high buffer, -> RESP.
- RESP: rsp_valid=1 for one cycle, -> IDLE. Load result = ({high,low} >> 8*off), then sign-extend bit 7/15 for 000/001, zero-extend for 100/101, pass 32 bits for 010.
- mem_req, mem_addr, mem_be, mem_we, mem_wdata held stable until mem_ack; req_valid ignored outside IDLE.

## Timing
- Reset (async assert): state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0, buffers cleared. Reset mid-access abandons the beat; no rsp_valid.
- Command accepted at edge T. With mem_ack high on first request cycle: single-beat rsp_valid at T+2; two-beat at T+3. Each wait cycle (mem_ack low) adds one cycle.
- Error responses: rsp_valid at T+1, mem_req never asserted.
- Next command may be accepted in the cycle after RESP (IDLE); no back-to-back overlap.

## Configuration
- LSU_MISALIGN_EN defined: any access with E[7:4]!=0 is split into two beats as above; halfword at off=1 is a single beat.
- Undefined: any access not naturally aligned (h with addr[0]=1, w with off!=0) -> rsp_err=1, no memory access; ACC1 unreachable.

## Test plan
- sb wdata=0x000000A5 addr=0x102, mem_ack=1 -> mem_addr=0x100, mem_be=0100, mem_wdata=0x00A50000, mem_we=1, rsp_valid at T+2, rsp_err=0.
- lb addr=0x103, mem_rdata=0x80FF1234 -> rsp_rdata=0xFFFFFF80; lbu same -> 0x00000080; lh addr=0x102 -> 0xFFFF80FF.
- LSU_MISALIGN_EN: lw addr=0x101, beats 0x100 be=1110 rdata 0x44332211, 0x104 be=0001 rdata 0x88776655 -> rsp_rdata=0x55443322 at T+3; sw addr=0xFFFFFFFE -> second beat mem_addr=0x00000000 be=0011. Without macro: rsp_err=1 at T+1, mem_req stays 0.
- req_funct3=011 load -> rsp_valid with rsp_err=1, rsp_rdata=0 at T+1, no mem_req.
- mem_ack low 5 cycles during ACC0 -> mem_req/mem_addr/mem_be stable, req_ready=0, rsp_valid at T+7; req_valid pulses ignored.
- rst_n low during ACC1 -> all outputs at reset values immediately, req_ready=1, no rsp_valid after release.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl - load/store unit for the memory stage.
//
// Takes one load/store command at a time from the core over a valid/ready
// handshake. It issues word-aligned memory beats with byte enables and
// lane-shifted write data. Loads return the addressed byte, halfword or word,
// sign- or zero-extended according to funct3.
//
// Build option: LSU_MISALIGN_EN
//   defined   - an access that crosses a word boundary is split into two beats
//   undefined - an access that is not naturally aligned is answered with
//               rsp_err and makes no memory access
//
// Ports
//   clk, rst_n                          clock, asynchronous active-low reset
//   req_valid/req_ready                 command handshake (ready only in IDLE)
//   req_we, req_funct3                  store flag and RV32I access size/sign
//   req_addr, req_wdata                 byte address, right-aligned store data
//   rsp_valid, rsp_rdata, rsp_err       one-cycle completion, load data, error
//   mem_req, mem_we, mem_addr           memory beat request (word aligned)
//   mem_be, mem_wdata                   byte enables, lane-shifted write data
//   mem_ack, mem_rdata                  beat accepted, read word in ack cycle
module lsu_mem_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

`ifdef LSU_MISALIGN_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

  state_t                  state, state_nxt;
  logic                    we_q;
  logic [2:0]              f3_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    err_q;
  logic [DATA_WIDTH-1:0]   lo_q, hi_q;

  // Legal funct3 for the direction; with splitting disabled, any access that
  // is not naturally aligned is also rejected.
  function automatic logic cmd_legal(input logic we, input logic [2:0] f3,
                                     input logic [1:0] off);
    logic ok;
    logic misalign;
    case (f3)
      3'b000, 3'b001, 3'b010: ok = 1'b1;
      3'b100, 3'b101:         ok = !we;
      default:                ok = 1'b0;
    endcase
    misalign = ((f3[1:0] == 2'b01) && off[0]) ||
               ((f3[1:0] == 2'b10) && (off != 2'b00));
    return ok && (SPLIT_EN || !misalign);
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] f3,
                                           input logic [31:0] w);
    logic [31:0] r;
    case (f3)
      3'b000:  r = {{24{w[7]}}, w[7:0]};
      3'b001:  r = {{16{w[15]}}, w[15:0]};
      3'b010:  r = w;
      3'b100:  r = {24'b0, w[7:0]};
      3'b101:  r = {16'b0, w[15:0]};
      default: r = 32'b0;
    endcase
    return r;
  endfunction

  logic                    req_legal;
  logic [1:0]              off;
  logic [4:0]              sh;
  logic [3:0]              size_mask;
  logic [7:0]              ben;
  logic [2*DATA_WIDTH-1:0] wide_w;
  logic [DATA_WIDTH-1:0]   load_word;
  logic [ADDR_WIDTH-1:0]   base_addr, next_addr;

  assign req_legal = cmd_legal(req_we, req_funct3, req_addr[1:0]);
  assign off       = addr_q[1:0];
  assign sh        = {off, 3'b000};

  always_comb begin
    case (f3_q[1:0])
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  end

  // Enables and data span two words; the upper half belongs to the second beat.
  assign ben       = {4'b0000, size_mask} << off;
  assign wide_w    = {{DATA_WIDTH{1'b0}}, wdata_q} << sh;
  assign load_word = DATA_WIDTH'({hi_q, lo_q} >> sh);
  assign base_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign next_addr = base_addr + ADDR_WIDTH'(4);

  // Stage boundary: command latch, beat read buffers and FSM state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req_valid) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        err_q   <= !req_legal;
        lo_q    <= '0;
        hi_q    <= '0;
      end
      if (state == ACC0 && mem_ack) lo_q <= mem_rdata;
      if (state == ACC1 && mem_ack) hi_q <= mem_rdata;
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    rsp_err   = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_be    = 4'b0000;
    mem_wdata = '0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = req_legal ? ACC0 : RESP;
      end
      ACC0: begin
        mem_req   = 1'b1;
        mem_we    = we_q;
        mem_addr  = base_addr;
        mem_be    = ben[3:0];
        mem_wdata = wide_w[DATA_WIDTH-1:0];
        if (mem_ack) state_nxt = (ben[7:4] != 4'b0000) ? ACC1 : RESP;
      end
      ACC1: begin
        mem_req   = 1'b1;
        mem_we    = we_q;
        mem_addr  = next_addr;
        mem_be    = ben[7:4];
        mem_wdata = wide_w[2*DATA_WIDTH-1:DATA_WIDTH];
        if (mem_ack) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = err_q;
        if (!we_q && !err_q) rsp_rdata = load_ext(f3_q, load_word);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Testbench for lsu_mem_ctrl. It runs directed scenarios and then randomized
// commands. Expected results come from a byte-level model of memory and of
// the access rules. The bench follows the LSU_MISALIGN_EN setting of the build.
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] mem [logic [31:0]];

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] memword(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a ^ 32'h5A5A_0000) * 32'h9E37_79B1 + 32'h1234_5678;
  endfunction

  function automatic logic [7:0] byte_at(input logic [31:0] a);
    logic [31:0] w;
    w = memword(a & ~32'h3);
    return 8'(w >> (8 * a[1:0]));
  endfunction

  function automatic int size_of(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_ready"},  req_ready, 1);
    chk({tag, "_rspv"},   rsp_valid, 0);
    chk({tag, "_rdata"},  rsp_rdata, 0);
    chk({tag, "_err"},    rsp_err, 0);
    chk({tag, "_mreq"},   mem_req, 0);
    chk({tag, "_mwe"},    mem_we, 0);
    chk({tag, "_maddr"},  mem_addr, 0);
    chk({tag, "_mbe"},    mem_be, 0);
    chk({tag, "_mwdata"}, mem_wdata, 0);
  endtask

  // Issue one command, act as the memory (w0/w1 wait cycles per beat),
  // and check each beat and the response against the model.
  task automatic run_cmd(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input int w0, input int w1);
    int          size, off, nb, expc, acked, p, idx;
    int          waits[2];
    bit          legal, done;
    logic [31:0] exp_rd, exp_a, exp_be, exp_wd;

    size = size_of(f3);
    off  = int'(addr[1:0]);
    legal = (f3 inside {3'd0, 3'd1, 3'd2}) || (!we && (f3 inside {3'd4, 3'd5}));
`ifndef LSU_MISALIGN_EN
    if ((size == 2 && addr[0]) || (size == 4 && off != 0)) legal = 1'b0;
`endif
    nb = !legal ? 0 : ((off + size > 4) ? 2 : 1);
    waits[0] = w0;
    waits[1] = w1;
    expc = legal ? (1 + nb + w0 + ((nb == 2) ? w1 : 0)) : 1;

    exp_rd = 32'h0;
    if (legal && !we) begin
      for (int i = 0; i < size; i++)
        exp_rd |= 32'(byte_at(addr + 32'(i))) << (8 * i);
      if (f3 == 3'd0 && exp_rd[7])  exp_rd |= 32'hFFFF_FF00;
      if (f3 == 3'd1 && exp_rd[15]) exp_rd |= 32'hFFFF_0000;
    end

    @(negedge clk);
    chk("ready_idle", req_ready, 1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    mem_ack    = 1'b0;
    @(posedge clk);

    acked = 0;
    done  = 1'b0;
    for (int c = 1; c <= 60 && !done; c++) begin
      @(negedge clk);
      mem_ack    = 1'b0;
      mem_rdata  = $urandom;
      req_valid  = 1'($urandom_range(0, 1));
      req_we     = 1'($urandom);
      req_funct3 = 3'($urandom);
      req_addr   = $urandom;
      req_wdata  = $urandom;
      if (rsp_valid) begin
        chk("rsp_cycle", 32'(c), 32'(expc));
        chk("rsp_err", rsp_err, {31'b0, !legal});
        chk("rsp_rdata", rsp_rdata, exp_rd);
        chk("beat_count", 32'(acked), 32'(nb));
        chk("mem_req_in_resp", mem_req, 0);
        req_valid = 1'b0;
        done = 1'b1;
      end else begin
        chk("ready_busy", req_ready, 0);
        if (!mem_req) begin
          chk("mem_req", mem_req, 1);
        end else if (acked >= nb) begin
          chk("extra_beat", mem_req, 0);
        end else begin
          exp_a  = (addr & ~32'h3) + 32'(4 * acked);
          exp_be = 32'h0;
          exp_wd = 32'h0;
          for (int j = 0; j < 4; j++) begin
            p   = 4 * acked + j;
            idx = p - off;
            if (p >= off && p < off + size) exp_be[j] = 1'b1;
            if (idx >= 0 && idx < 4) exp_wd[8*j +: 8] = wdata[8*idx +: 8];
          end
          chk("mem_addr", mem_addr, exp_a);
          chk("mem_be", {28'b0, mem_be}, exp_be);
          chk("mem_we", mem_we, {31'b0, we});
          chk("mem_wdata", mem_wdata, exp_wd);
          if (waits[acked] > 0) begin
            waits[acked]--;
          end else begin
            mem_ack   = 1'b1;
            mem_rdata = memword(exp_a);
            acked++;
          end
        end
      end
    end
    mem_ack = 1'b0;
    if (!done) chk("rsp_timeout", 0, 1);
  endtask

  // Reset in the middle of an access: outputs must drop at once and no
  // response may follow.
  task automatic reset_mid();
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'd2;
`ifdef LSU_MISALIGN_EN
    req_addr   = 32'h0000_0101;
`else
    req_addr   = 32'h0000_0200;
`endif
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
`ifdef LSU_MISALIGN_EN
    mem_ack   = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
`endif
    @(negedge clk);
    mem_ack = 1'b0;
    chk("pre_rst_mem_req", mem_req, 1);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("no_rsp_after_rst", rsp_valid, 0);
      chk("ready_after_rst", req_ready, 1);
    end
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] a;
    int          w0, w1;

    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    mem_ack    = 1'b0;
    mem_rdata  = 32'h0;
    #1;
    check_idle_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    mem[32'h100] = 32'h80FF_1234;
    run_cmd(1'b1, 3'd0, 32'h0000_0102, 32'h0000_00A5, 0, 0);
    run_cmd(1'b0, 3'd0, 32'h0000_0103, 32'h0, 0, 0);
    run_cmd(1'b0, 3'd4, 32'h0000_0103, 32'h0, 0, 0);
    run_cmd(1'b0, 3'd1, 32'h0000_0102, 32'h0, 1, 0);
    run_cmd(1'b0, 3'd5, 32'h0000_0102, 32'h0, 0, 0);

    mem[32'h100] = 32'h4433_2211;
    mem[32'h104] = 32'h8877_6655;
    run_cmd(1'b0, 3'd2, 32'h0000_0101, 32'h0, 0, 0);
    run_cmd(1'b1, 3'd2, 32'hFFFF_FFFE, 32'hCAFE_F00D, 0, 2);
    run_cmd(1'b0, 3'd3, 32'h0000_0100, 32'h0, 0, 0);
    run_cmd(1'b1, 3'd4, 32'h0000_0100, 32'h1, 0, 0);
    run_cmd(1'b0, 3'd2, 32'h0000_0100, 32'h0, 5, 0);
    run_cmd(1'b1, 3'd1, 32'h0000_0101, 32'h0000_BEEF, 0, 0);
    run_cmd(1'b0, 3'd1, 32'h0000_0103, 32'h0, 1, 1);

    for (int n = 0; n < 80; n++) begin
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
      else a = 32'h0000_1000 + 32'($urandom_range(0, 63));
      w0 = ($urandom_range(0, 7) == 0) ? 4 : int'($urandom_range(0, 2));
      w1 = int'($urandom_range(0, 2));
      run_cmd(1'($urandom), f3, a, $urandom, w0, w1);
    end

    reset_mid();
    run_cmd(1'b0, 3'd2, 32'h0000_0100, 32'h0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
